// File: rtl/pipeline_1.sv
// -----------------------------------------------------------------------------
// pipeline_1 : IF/ID pipeline register of the pipelined RISC-V CPU.
//
// Captures the fetched instruction and its PC+4 on each rising clock edge and
// presents them to decode. The pair is held while memory reports busy-wait,
// and a synchronous reset loads a bubble (nop-like zero word, PC+4 = -4 so the
// first fetch after reset lines up with PC 0).
//
// Ports:
//   CLK                in   system clock, rising-edge active
//   RESET              in   synchronous, active-high; wins over BUSY_WAIT
//   INSTRUCTION        in   instruction word from instruction memory
//   PC_INCREMENT4      in   PC+4 from fetch
//   BUSY_WAIT          in   1 = hold current contents
//   INSTRUCTION_OUT    out  registered instruction to decode
//   PC_INCREMENT4_OUT  out  registered PC+4 to decode
// -----------------------------------------------------------------------------
module pipeline_1 #(
   parameter int                  DATA_WIDTH  = 32,
   parameter logic [DATA_WIDTH-1:0] INSTR_RESET = 32'h0000_0000,
   parameter logic [DATA_WIDTH-1:0] PC4_RESET   = 32'hFFFF_FFFC
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [DATA_WIDTH-1:0] INSTRUCTION,
   input  logic [DATA_WIDTH-1:0] PC_INCREMENT4,
   input  logic                  BUSY_WAIT,
   output logic [DATA_WIDTH-1:0] INSTRUCTION_OUT,
   output logic [DATA_WIDTH-1:0] PC_INCREMENT4_OUT
);

   // Both fields live in one register so they can only update or hold as a
   // unit; a split update would pair an instruction with the wrong PC+4.
   typedef struct packed {
      logic [DATA_WIDTH-1:0] instr;
      logic [DATA_WIDTH-1:0] pc4;
   } if_id_t;

   if_id_t stage_q;
   if_id_t stage_d;

   always_comb begin
      stage_d.instr = INSTRUCTION;
      stage_d.pc4   = PC_INCREMENT4;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         stage_q.instr <= INSTR_RESET;
         stage_q.pc4   <= PC4_RESET;
      end else if (!BUSY_WAIT) begin
         stage_q <= stage_d;
      end
   end

   // Outputs come straight from the register: no input-to-output path.
   assign INSTRUCTION_OUT   = stage_q.instr;
   assign PC_INCREMENT4_OUT = stage_q.pc4;

endmodule

// File: tb/tb_pipeline_1.sv
`timescale 1ns/100ps
// -----------------------------------------------------------------------------
// tb_pipeline_1 : scoreboard bench for the IF/ID register.
// Stimulus drives inputs on the falling edge and queues the value each output
// must hold after the following rising edge. The monitor pops one entry at
// every rising edge +2 ns and, at falling edge +2 ns (after the inputs have
// moved mid-cycle), checks that the outputs have not followed the inputs.
// -----------------------------------------------------------------------------
module tb_pipeline_1;

   typedef struct packed {
      logic [31:0] i;
      logic [31:0] p;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [31:0] instr;
   logic [31:0] pc4;
   logic        bw;
   logic [31:0] instr_out;
   logic [31:0] pc4_out;

   exp_t q[$];
   exp_t cur;
   bit   have_cur;
   int   n_cmp;
   int   n_err;

   localparam logic [31:0] M4 = 32'hFFFF_FFFC;

   pipeline_1 dut (
      .CLK              (clk),
      .RESET            (rst),
      .INSTRUCTION      (instr),
      .PC_INCREMENT4    (pc4),
      .BUSY_WAIT        (bw),
      .INSTRUCTION_OUT  (instr_out),
      .PC_INCREMENT4_OUT(pc4_out)
   );

   initial clk = 1'b0;
   always #4 clk = ~clk;

   task automatic check(input string name, input exp_t e);
      n_cmp++;
      if (instr_out !== e.i || pc4_out !== e.p) begin
         n_err++;
         $display("FAIL %s @%0t: got instr=%h pc4=%h, required instr=%h pc4=%h",
                  name, $time, instr_out, pc4_out, e.i, e.p);
      end
   endtask

   // Monitor
   initial begin
      have_cur = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            cur      = q.pop_front();
            have_cur = 1'b1;
            check("after_edge", cur);
         end
         @(negedge clk);
         #2;
         if (have_cur) check("mid_cycle_stable", cur);
      end
   end

   // One cycle: drive at falling edge, queue expected output after next rise.
   task automatic cyc(input logic [31:0] i, input logic [31:0] p, input logic b,
                      input logic r, input logic [31:0] ei, input logic [31:0] ep);
      exp_t e;
      @(negedge clk);
      instr = i; pc4 = p; bw = b; rst = r;
      e.i = ei; e.p = ep;
      q.push_back(e);
   endtask

   initial begin
      exp_t e;
      n_cmp = 0;
      n_err = 0;
      instr = 32'd10; pc4 = 32'd20; bw = 1'b0; rst = 1'b0;
      // Reset pulse t=1..6 spanning the rising edge at t=4.
      #1 rst = 1'b1;
      e.i = 32'd0; e.p = M4;
      q.push_back(e);
      #5 rst = 1'b0;

      cyc(32'd16, 32'd25, 1'b0, 1'b0, 32'd16, 32'd25);   // normal write
      cyc(32'd3,  32'd80, 1'b1, 1'b0, 32'd16, 32'd25);   // stall
      cyc(32'd3,  32'd80, 1'b1, 1'b0, 32'd16, 32'd25);
      cyc(32'd3,  32'd80, 1'b1, 1'b0, 32'd16, 32'd25);
      cyc(32'd3,  32'd80, 1'b0, 1'b0, 32'd3,  32'd80);   // release
      cyc(32'd3,  32'd80, 1'b1, 1'b1, 32'd0,  M4);       // reset beats stall
      cyc(32'd3,  32'd80, 1'b1, 1'b0, 32'd0,  M4);       // still stalled
      cyc(32'd3,  32'd80, 1'b0, 1'b0, 32'd3,  32'd80);   // reload on release
      cyc(32'h0000_0013, 32'd4,  1'b0, 1'b0, 32'h0000_0013, 32'd4);
      cyc(32'hDEAD_BEEF, 32'd8,  1'b0, 1'b0, 32'hDEAD_BEEF, 32'd8);
      cyc(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      cyc(32'h1234_5678, 32'd12, 1'b0, 1'b1, 32'd0, M4); // plain reset
      cyc(32'h0000_0093, 32'd0,  1'b0, 1'b0, 32'h0000_0093, 32'd0);
      cyc(32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h0000_0093, 32'd0);
      cyc(32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h8000_0000);

      // Drain the scoreboard within a bounded number of cycles.
      for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
      @(negedge clk);
      #3;
      n_cmp++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d entries left, required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
